// File: rtl/uart_tx_param.sv
// uart_tx_param
//   Buffered UART transmitter. Characters written on wr_en are queued in a
//   FIFO and sent LSB first as: start bit, DATA_W data bits, optional parity
//   bit, one or two stop bits. Bit timing is taken from the external baud
//   enable (one clk high per bit period); frames run back-to-back while the
//   FIFO holds data.
//
//   Ports
//     clk, rst_n       system clock, synchronous active-low reset
//     baud             bit-period enable tick
//     wr_en, wr_data   push a character into the TX FIFO
//     parity_en        insert a parity bit after the data bits
//     parity_odd       odd (1) or even (0) parity
//     two_stop         two stop bits (1) or one (0)
//     txd              serial output, idle high
//     tbr              FIFO not full
//     busy             frame in progress
//     fifo_count       FIFO occupancy, 0..FIFO_DEPTH
//     overflow         one-clk pulse when a write hits a full FIFO
module uart_tx_param #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              baud,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              parity_en,
   input  logic              parity_odd,
   input  logic              two_stop,
   output logic              txd,
   output logic              tbr,
   output logic              busy,
   output logic [CNT_W-1:0]  fifo_count,
   output logic              overflow
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned BC_W  = $clog2(DATA_W + 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [DATA_W-1:0] shift;
   logic [BC_W-1:0]   bit_cnt;
   logic              par_en_l;
   logic              par_bit_l;
   logic              two_stop_l;
   logic              stop_cnt;

   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              last_stop;
   logic [DATA_W-1:0] head;
   logic [CNT_W-1:0]  count_nxt;

   always_comb begin
      full      = (fifo_count == CNT_W'(FIFO_DEPTH));
      empty     = (fifo_count == '0);
      // Full check uses the current count, so a same-cycle pop never frees a slot.
      push      = wr_en && !full;
      last_stop = (state == STOP) && (!two_stop_l || stop_cnt);
      // A frame starts either from IDLE or directly off the final stop period.
      pop       = baud && !empty && ((state == IDLE) || last_stop);
      head      = mem[rd_ptr];
      count_nxt = fifo_count;
      if (push && !pop) begin
         count_nxt = fifo_count + CNT_W'(1);
      end else if (pop && !push) begin
         count_nxt = fifo_count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
         tbr        <= 1'b1;
         state      <= IDLE;
         txd        <= 1'b1;
         busy       <= 1'b0;
         shift      <= '0;
         bit_cnt    <= '0;
         par_en_l   <= 1'b0;
         par_bit_l  <= 1'b0;
         two_stop_l <= 1'b0;
         stop_cnt   <= 1'b0;
      end else begin
         overflow   <= wr_en && full;
         fifo_count <= count_nxt;
         tbr        <= (count_nxt != CNT_W'(FIFO_DEPTH));
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            // Frame start shared by IDLE and the back-to-back STOP exit.
            rd_ptr     <= rd_ptr + PTR_W'(1);
            shift      <= head;
            par_en_l   <= parity_en;
            par_bit_l  <= (^head) ^ parity_odd;
            two_stop_l <= two_stop;
            txd        <= 1'b0;
            busy       <= 1'b1;
            state      <= START;
         end else if (baud) begin
            case (state)
               IDLE: begin
                  txd <= 1'b1;
               end
               START: begin
                  txd     <= shift[0];
                  shift   <= shift >> 1;
                  bit_cnt <= BC_W'(1);
                  state   <= DATA;
               end
               DATA: begin
                  if (bit_cnt < BC_W'(DATA_W)) begin
                     txd     <= shift[0];
                     shift   <= shift >> 1;
                     bit_cnt <= bit_cnt + BC_W'(1);
                  end else if (par_en_l) begin
                     txd   <= par_bit_l;
                     state <= PARITY;
                  end else begin
                     txd      <= 1'b1;
                     stop_cnt <= 1'b0;
                     state    <= STOP;
                  end
               end
               PARITY: begin
                  txd      <= 1'b1;
                  stop_cnt <= 1'b0;
                  state    <= STOP;
               end
               STOP: begin
                  txd <= 1'b1;
                  if (last_stop) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     stop_cnt <= 1'b1;
                  end
               end
               default: begin
                  txd   <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: an 8-bit/8-deep instance for the main
// scenarios and a 7-bit/4-deep instance for the narrow-data case.
module tb_uart_tx_param;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       baud;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       parity_en;
   logic       parity_odd;
   logic       two_stop;
   logic       txd;
   logic       tbr;
   logic       busy;
   logic [3:0] fifo_count;
   logic       overflow;

   logic       wr_en7;
   logic [6:0] wr_data7;
   logic       txd7;
   logic       tbr7;
   logic       busy7;
   logic [2:0] fifo_count7;
   logic       overflow7;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   uart_tx_param #(.DATA_W(8), .FIFO_DEPTH(8)) u (
      .clk(clk), .rst_n(rst_n), .baud(baud), .wr_en(wr_en), .wr_data(wr_data),
      .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
      .txd(txd), .tbr(tbr), .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
   );

   uart_tx_param #(.DATA_W(7), .FIFO_DEPTH(4)) u7 (
      .clk(clk), .rst_n(rst_n), .baud(baud), .wr_en(wr_en7), .wr_data(wr_data7),
      .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
      .txd(txd7), .tbr(tbr7), .busy(busy7), .fifo_count(fifo_count7), .overflow(overflow7)
   );

   typedef struct {
      logic [7:0]  data;
      logic        pen;
      logic        podd;
      logic        two;
      logic [11:0] bits;   // bit i = txd in baud period i
      int          len;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One baud period of 4 clk; returns on a negedge after the baud edge.
   task automatic tick();
      @(negedge clk);
      baud = 1'b1;
      @(negedge clk);
      baud = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic write8(input logic [7:0] d);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic write7(input logic [6:0] d);
      @(negedge clk);
      wr_en7   = 1'b1;
      wr_data7 = d;
      @(negedge clk);
      wr_en7   = 1'b0;
   endtask

   // Tick through periods lo..hi, comparing txd to exp[i] and requiring busy.
   task automatic run_seq(input logic [31:0] exp, input int lo, input int hi,
                          input string name, input bit use7);
      logic [31:0] e;
      e = exp;
      for (int i = lo; i <= hi; i++) begin
         tick();
         chk($sformatf("%s txd[%0d]", name, i), use7 ? txd7 : txd, e[i]);
         chk($sformatf("%s busy[%0d]", name, i), use7 ? busy7 : busy, 1'b1);
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] got;
      int         ones;

      vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 12'h34A, 10};  // 8N1
      vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 12'h60E, 11};  // 8E1, parity 1
      vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 12'h40E, 11};  // 8O1, parity 0
      vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b0, 12'h400, 11};  // 8E1, parity 0
      vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 12'hFFE, 12};  // 8O2, parity 1

      rst_n = 1'b0; baud = 1'b0; wr_en = 1'b0; wr_data = '0;
      wr_en7 = 1'b0; wr_data7 = '0;
      parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst txd", txd, 1'b1);
      chk("rst tbr", tbr, 1'b1);
      chk("rst busy", busy, 1'b0);
      chk("rst fifo_count", fifo_count, 4'd0);
      chk("rst overflow", overflow, 1'b0);
      chk("rst txd7", txd7, 1'b1);
      rst_n = 1'b1;
      @(negedge clk);

      // Table of single frames
      for (int v = 0; v < 5; v++) begin
         parity_en  = vecs[v].pen;
         parity_odd = vecs[v].podd;
         two_stop   = vecs[v].two;
         write8(vecs[v].data);
         chk($sformatf("v%0d count pre", v), fifo_count, 4'd1);
         for (int i = 0; i < vecs[v].len; i++) begin
            tick();
            chk($sformatf("v%0d txd[%0d]", v, i), txd, vecs[v].bits[i]);
            if (i == 0) begin
               chk($sformatf("v%0d busy start", v), busy, 1'b1);
               chk($sformatf("v%0d count popped", v), fifo_count, 4'd0);
            end
         end
         tick();
         chk($sformatf("v%0d idle txd", v), txd, 1'b1);
         chk($sformatf("v%0d idle busy", v), busy, 1'b0);
      end

      // Back-to-back 8N2: 0x55 then 0x0F, no idle gap
      parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b1;
      write8(8'h55);
      write8(8'h0F);
      chk("b2b count", fifo_count, 4'd2);
      run_seq(32'({11'h61E, 11'h6AA}), 0, 21, "b2b", 1'b0);
      tick();
      chk("b2b idle txd", txd, 1'b1);
      chk("b2b idle busy", busy, 1'b0);

      // Fill FIFO with baud idle; ninth write overflows and is dropped
      two_stop = 1'b0;
      for (int k = 0; k < 8; k++) begin
         write8(8'h11 + 8'(k));
         if (k == 6) chk("fill tbr at 7", tbr, 1'b1);
      end
      chk("fill tbr at 8", tbr, 1'b0);
      chk("fill count 8", fifo_count, 4'd8);
      chk("fill no overflow", overflow, 1'b0);
      write8(8'h99);
      chk("overflow pulse", overflow, 1'b1);
      chk("overflow count", fifo_count, 4'd8);
      @(negedge clk);
      chk("overflow cleared", overflow, 1'b0);

      // Drain with baud held high: eight 10-period frames, then idle
      baud = 1'b1;
      got  = '0;
      for (int t = 0; t <= 80; t++) begin
         @(negedge clk);
         if (t == 70) chk("drain last start", txd, 1'b0);
         if (t >= 71 && t <= 78) got[t-71] = txd;
         if (t == 79) chk("drain last stop busy", busy, 1'b1);
      end
      baud = 1'b0;
      chk("drain last data", got, 8'h18);
      chk("drain idle txd", txd, 1'b1);
      chk("drain idle busy", busy, 1'b0);
      chk("drain count", fifo_count, 4'd0);
      chk("drain tbr", tbr, 1'b1);

      // Reset mid-DATA of 0x3C with another word still queued
      write8(8'h3C);
      write8(8'h77);
      tick(); tick(); tick();   // start, b0=0, b1=0
      chk("mid txd low", txd, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort txd", txd, 1'b1);
      chk("abort busy", busy, 1'b0);
      chk("abort count", fifo_count, 4'd0);
      chk("abort tbr", tbr, 1'b1);
      rst_n = 1'b1;
      ones = 0;
      for (int t = 0; t < 12; t++) begin
         tick();
         if (txd === 1'b1 && busy === 1'b0) ones++;
      end
      chk("post-reset quiet", ones, 12);

      // Config changes mid-frame apply only to the next frame
      parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
      write8(8'hA5);
      write8(8'h07);
      run_seq(32'({12'hE0E, 10'h34A}), 0, 2, "cfg", 1'b0);
      parity_en = 1'b1; two_stop = 1'b1;
      run_seq(32'({12'hE0E, 10'h34A}), 3, 21, "cfg", 1'b0);
      tick();
      chk("cfg idle busy", busy, 1'b0);

      // Seven-bit instance: 0x41 as 7N1
      parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
      write7(7'h41);
      chk("w7 count", fifo_count7, 3'd1);
      run_seq(32'h182, 0, 8, "w7", 1'b1);
      tick();
      chk("w7 idle txd", txd7, 1'b1);
      chk("w7 idle busy", busy7, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
